// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RISC-V instruction fetch front end.
package rv_fetch_pkg;

   localparam int unsigned XLEN    = 64;
   localparam int unsigned ILEN    = 32;
   localparam int unsigned PC_STEP = 4;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] ins;
   } fetch_entry_t;

   localparam int unsigned FE_W = $bits(fetch_entry_t);

   // Bubble encoding (addi x0,x0,0) for the datapath; fetch never inserts it.
   localparam logic [ILEN-1:0] NOP_INS = 32'h0000_0013;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch front-end bus: imem request/response, redirect and instruction handshake.
interface inst_fetch_queue_if;
   import rv_fetch_pkg::*;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [ILEN-1:0] imem_resp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            ins_valid;
   logic            ins_ready;
   logic [ILEN-1:0] ins;
   logic [XLEN-1:0] ins_pc;

   modport master (
      output imem_req_valid, imem_req_addr, ins_valid, ins, ins_pc,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
             redirect_valid, redirect_pc, ins_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, ins_valid, ins, ins_pc,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
             redirect_valid, redirect_pc, ins_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Shift-register FIFO of {pc, ins}; the head is always entry 0 so it leaves straight from a flop.
module fetch_fifo
   import rv_fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output fetch_entry_t     head
);

   fetch_entry_t     entries_q [DEPTH];
   fetch_entry_t     entries_d [DEPTH];
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Pop shifts toward the head first, then a push lands in the first free slot.
   always_comb begin
      entries_d = entries_q;
      count_d   = count_q;
      if (flush) begin
         count_d = '0;
      end else begin
         if (pop && (count_q != '0)) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
               entries_d[i] = entries_q[i+1];
            end
            count_d = count_q - CNT_W'(1);
         end
         if (push && (count_d < CNT_W'(DEPTH))) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (CNT_W'(i) == count_d) begin
                  entries_d[i] = push_data;
               end
            end
            count_d = count_d + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entries_q <= '{default: '0};
         count_q   <= '0;
      end else begin
         entries_q <= entries_d;
         count_q   <= count_d;
      end
   end

   assign count = count_q;
   assign head  = entries_q[0];

endmodule

// File: rtl/inst_fetch_queue.sv
// Sequential instruction fetcher with credit-limited requests, response buffering and redirect flush.
module inst_fetch_queue
   import rv_fetch_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic                 clk,
   input logic                 reset,
   inst_fetch_queue_if.master  bus
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned CRD_W = CNT_W + 1;

   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic             run_q;

   logic [CNT_W-1:0] fifo_count;
   fetch_entry_t     fifo_head;
   fetch_entry_t     push_entry;
   logic [CRD_W-1:0] credit_c;
   logic             req_valid_c;
   logic             req_fire;
   logic             push;
   logic             pop;

   // Oldest live request PC is fetch_pc minus one step per outstanding request.
   always_comb begin
      credit_c    = CRD_W'(fifo_count) + CRD_W'(inflight_q) - CRD_W'(drop_q);
      req_valid_c = run_q && !bus.redirect_valid && (credit_c < CRD_W'(DEPTH));
      req_fire    = req_valid_c && bus.imem_req_ready;
      push        = bus.imem_resp_valid && (drop_q == '0) && !bus.redirect_valid;
      pop         = (fifo_count != '0) && bus.ins_ready && !bus.redirect_valid;
      push_entry.pc  = fetch_pc_q - (XLEN'(inflight_q) * XLEN'(PC_STEP));
      push_entry.ins = bus.imem_resp_data;
   end

   // Redirect reclassifies every response still to arrive as one to discard.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(bus.imem_resp_valid);
      drop_d     = drop_q;
      if (bus.redirect_valid) begin
         fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
         drop_d     = inflight_q - CNT_W'(bus.imem_resp_valid);
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
         end
         if (bus.imem_resp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
         run_q      <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         run_q      <= 1'b1;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (bus.redirect_valid),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   assign bus.imem_req_valid = req_valid_c;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.ins_valid      = (fifo_count != '0);
   assign bus.ins            = fifo_head.ins;
   assign bus.ins_pc         = fifo_head.pc;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue with an in-order variable-latency memory model.
module tb_inst_fetch_queue;
   import rv_fetch_pkg::*;

   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [63:0] addr;
      int          due;
   } mreq_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   inst_fetch_queue_if bus ();

   inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   mreq_t        mem_q [$];
   fetch_entry_t exp_q [$];
   logic [63:0]  popped_q [$];
   logic [63:0]  fired_q [$];

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc;
   int          lat;
   int          m_count;
   int          m_drop;
   int          fires;
   int          first_iv;
   logic [63:0] exp_pc;
   logic        ins_rdy;
   logic        req_rdy;
   logic        redir;
   logic [63:0] redir_pc;

   function automatic logic [31:0] mem_word(logic [63:0] a);
      return a[33:2] ^ 32'hC0DE_0013;
   endfunction

   task automatic check_eq(string tag, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic timeout(string tag);
      n_checks++;
      n_errors++;
      $display("FAIL %s: wait expired", tag);
   endtask

   // One clock of stimulus, sampling and model update, all around the falling edge.
   task automatic step();
      logic         resp;
      logic         exp_rv;
      fetch_entry_t e;
      @(negedge clk);
      resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      bus.imem_resp_valid = resp;
      bus.imem_resp_data  = resp ? mem_word(mem_q[0].addr) : 32'h0;
      bus.redirect_valid  = redir;
      bus.redirect_pc     = redir_pc;
      bus.ins_ready       = ins_rdy;
      bus.imem_req_ready  = req_rdy;
      #1;
      exp_rv = !redir && ((m_count + mem_q.size() - m_drop) < DEPTH);
      check_eq("req_valid", 64'(bus.imem_req_valid), 64'(exp_rv));
      check_eq("ins_valid", 64'(bus.ins_valid), 64'(m_count > 0));
      if (bus.ins_valid && first_iv < 0) first_iv = cyc;
      if (bus.imem_req_valid && req_rdy) begin
         check_eq("req_addr", bus.imem_req_addr, exp_pc);
         mem_q.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
         exp_q.push_back('{pc: bus.imem_req_addr, ins: mem_word(bus.imem_req_addr)});
         fired_q.push_back(bus.imem_req_addr);
         exp_pc = exp_pc + 64'd4;
         fires++;
      end
      if (m_count > 0 && ins_rdy && !redir) begin
         if (exp_q.size() == 0) begin
            timeout("pop_underflow");
         end else begin
            e = exp_q.pop_front();
            check_eq("ins_pc", bus.ins_pc, e.pc);
            check_eq("ins", 64'(bus.ins), 64'(e.ins));
         end
         popped_q.push_back(bus.ins_pc);
         m_count--;
      end
      if (resp) begin
         void'(mem_q.pop_front());
         if (m_drop > 0) m_drop--;
         else if (!redir) m_count++;
      end
      if (redir) begin
         exp_q.delete();
         popped_q.delete();
         fired_q.delete();
         m_count = 0;
         m_drop  = mem_q.size();
         exp_pc  = redir_pc & ~64'h3;
      end
      cyc++;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_model();
      mem_q.delete();
      exp_q.delete();
      popped_q.delete();
      fired_q.delete();
      m_count  = 0;
      m_drop   = 0;
      exp_pc   = 64'h0;
      fires    = 0;
      first_iv = -1;
      cyc      = 0;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = 64'h0;
      bus.ins_ready       = 1'b0;
      bus.imem_req_ready  = 1'b0;
      redir = 1'b0;
      clear_model();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_eq("rst_req_valid", 64'(bus.imem_req_valid), 64'h0);
      check_eq("rst_ins_valid", 64'(bus.ins_valid), 64'h0);
      check_eq("rst_ins", 64'(bus.ins), 64'h0);
      check_eq("rst_ins_pc", bus.ins_pc, 64'h0);
      check_eq("rst_req_addr", bus.imem_req_addr, 64'h0);
      reset = 1'b1;
   endtask

   task automatic redirect_to(logic [63:0] pc);
      redir    = 1'b1;
      redir_pc = pc;
      step();
      redir = 1'b0;
   endtask

   task automatic run_until_pops(int n, string tag);
      int k;
      for (k = 0; k < 60 && popped_q.size() < n; k++) step();
      if (popped_q.size() < n) timeout(tag);
   endtask

   initial begin
      logic [63:0] held;
      int          k;
      ins_rdy  = 1'b1;
      req_rdy  = 1'b1;
      redir    = 1'b0;
      redir_pc = 64'h0;
      lat      = 1;

      // Streaming at latency 1: sequential addresses, first instruction in cycle 3.
      apply_reset();
      run(16);
      check_eq("first_ins_cycle", 64'(first_iv), 64'd2);
      check_eq("stream_pc0", popped_q[0], 64'h0);
      check_eq("stream_pc5", popped_q[5], 64'h14);

      // Stalled consumer: credit caps issue at DEPTH, then drain in order.
      ins_rdy = 1'b0;
      apply_reset();
      run(10);
      check_eq("stall_fires", 64'(fires), 64'd4);
      check_eq("stall_req_valid", 64'(bus.imem_req_valid), 64'h0);
      check_eq("stall_buffered", 64'(exp_q.size()), 64'd4);
      ins_rdy = 1'b1;
      run(8);
      check_eq("drain_pc3", popped_q[3], 64'hC);

      // Latency 3 with requests outstanding, redirect to a misaligned target.
      lat = 3;
      apply_reset();
      for (k = 0; k < 20 && mem_q.size() < 2; k++) step();
      if (mem_q.size() < 2) timeout("wait_inflight");
      redirect_to(64'h1002);
      run_until_pops(1, "wait_redir_pop");
      check_eq("redir_first_fetch", fired_q[0], 64'h1000);
      check_eq("redir_first_pc", popped_q[0], 64'h1000);
      run(10);

      // Redirect colliding with a live response and a pop.
      lat = 2;
      for (k = 0; k < 40; k++) begin
         if (mem_q.size() > 0 && mem_q[0].due <= cyc && m_drop == 0 && m_count > 0) break;
         step();
      end
      if (k == 40) timeout("wait_collision");
      redirect_to(64'h2000);
      @(posedge clk);
      #1;
      check_eq("flush_empty", 64'(bus.ins_valid), 64'h0);
      run_until_pops(1, "wait_collide_pop");
      check_eq("collide_first_pc", popped_q[0], 64'h2000);

      // Memory backpressure: address holds while not accepted.
      lat = 1;
      run(4);
      req_rdy = 1'b0;
      step();
      held = bus.imem_req_addr;
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("hold_addr", bus.imem_req_addr, held);
      end
      req_rdy = 1'b1;
      run(12);

      // Wrap at the top of the address space, then async reset mid-stream.
      redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
      run_until_pops(2, "wait_wrap");
      check_eq("wrap_pc0", popped_q[0], 64'hFFFF_FFFF_FFFF_FFFC);
      check_eq("wrap_pc1", popped_q[1], 64'h0);
      check_eq("wrap_fetch1", fired_q[1], 64'h0);
      for (k = 0; k < 20 && !bus.ins_valid; k++) step();
      if (!bus.ins_valid) timeout("wait_valid_before_reset");
      #2;
      reset = 1'b0;
      #1;
      check_eq("async_ins_valid", 64'(bus.ins_valid), 64'h0);
      check_eq("async_req_valid", 64'(bus.imem_req_valid), 64'h0);
      check_eq("async_req_addr", bus.imem_req_addr, 64'h0);
      apply_reset();
      run(8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
